// File: rtl/prio_arb_pkg.sv
// Shared types and helpers for the round-robin priority arbiter.
package prio_arb_pkg;

    // Arbiter FSM: waiting for requests, or holding a grant until ack/withdrawal.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Selection index width; never below 1 so that N=2 still gets a real bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational picker: lowest priority value wins, ties resolved by rotation
// order starting just after the last acknowledged source.
module rr_prio_pick
    import prio_arb_pkg::*;
#(
    parameter int N         = 8,
    parameter int PRIO_BITS = 3,
    localparam int SEL_W    = sel_width(N)
) (
    input  logic [N-1:0]           req,
    input  logic [N*PRIO_BITS-1:0] prio,
    input  logic [SEL_W-1:0]       last,
    output logic                   any,
    output logic [SEL_W-1:0]       sel,
    output logic [PRIO_BITS-1:0]   prio_min
);

    logic [PRIO_BITS-1:0] prio_arr [N];
    int                   idx;
    logic [SEL_W-1:0]     idx_s;

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign prio_arr[k] = prio[k*PRIO_BITS +: PRIO_BITS];
    end

    // Rotated linear scan; strict less-than keeps the first tied source found.
    always_comb begin
        any      = 1'b0;
        sel      = '0;
        prio_min = '0;
        idx      = 0;
        idx_s    = '0;
        for (int i = 0; i < N; i++) begin
            idx   = (int'(last) + 1 + i) % N;
            idx_s = SEL_W'(idx);
            if (req[idx_s] && (!any || (prio_arr[idx_s] < prio_min))) begin
                any      = 1'b1;
                sel      = idx_s;
                prio_min = prio_arr[idx_s];
            end
        end
    end

endmodule

// File: rtl/prio_arbiter_rr.sv
// Registered N-source priority arbiter with grant/ack handshake.
// Handshake: in IDLE any request is captured on the next edge and the grant is
// held frozen (gnt_valid_o=1) until ack_i=1 at an edge (completes, rotation
// advances) or the granted source drops its request (withdrawn, no rotation).
// ack_i wins over a simultaneous drop. One idle cycle separates grants.
module prio_arbiter_rr
    import prio_arb_pkg::*;
#(
    parameter int N         = 8,
    parameter int PRIO_BITS = 3,
    localparam int SEL_W    = sel_width(N)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N-1:0]           req_i,
    input  logic [N*PRIO_BITS-1:0] prio_i,
    input  logic                   ack_i,
    output logic                   gnt_valid_o,
    output logic [SEL_W-1:0]       gnt_sel_o,
    output logic [PRIO_BITS-1:0]   gnt_prio_o,
    output logic [N-1:0]           gnt_onehot_o
);

    localparam logic [N-1:0]     ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(N - 1);

    arb_state_e           state_q, state_d;
    logic [SEL_W-1:0]     last_q, last_d;
    logic                 valid_q, valid_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [PRIO_BITS-1:0] prio_q, prio_d;
    logic [N-1:0]         onehot_q, onehot_d;

    logic                 pick_any;
    logic [SEL_W-1:0]     pick_sel;
    logic [PRIO_BITS-1:0] pick_prio;

    rr_prio_pick #(
        .N         (N),
        .PRIO_BITS (PRIO_BITS)
    ) u_pick (
        .req      (req_i),
        .prio     (prio_i),
        .last     (last_q),
        .any      (pick_any),
        .sel      (pick_sel),
        .prio_min (pick_prio)
    );

    // Next-state and next-output logic; grant fields are frozen while held.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    valid_d = 1'b1;
                    sel_d   = pick_sel;
                    prio_d  = pick_prio;
                end
            end
            ST_GRANT: begin
                if (ack_i) begin
                    last_d  = sel_q;
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    sel_d   = '0;
                    prio_d  = '0;
                end else if (!req_i[sel_q]) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    sel_d   = '0;
                    prio_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                sel_d   = '0;
                prio_d  = '0;
            end
        endcase
        onehot_d = valid_d ? (ONE << sel_d) : '0;
    end

    // State, rotation pointer and grant registers; async reset drops any grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            last_q   <= LAST_RST;
            valid_q  <= 1'b0;
            sel_q    <= '0;
            prio_q   <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            sel_q    <= sel_d;
            prio_q   <= prio_d;
            onehot_q <= onehot_d;
        end
    end

    assign gnt_valid_o  = valid_q;
    assign gnt_sel_o    = sel_q;
    assign gnt_prio_o   = prio_q;
    assign gnt_onehot_o = onehot_q;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Bench for prio_arbiter_rr: an 8-source and a 5-source instance, a reference
// model of the pick rule, an expected-grant queue per instance and a monitor.
module tb_prio_arbiter_rr;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 8-source instance
    logic [7:0]  req8  = '0;
    logic [23:0] prio8 = '0;
    logic        ack8  = 1'b0;
    logic        v8;
    logic [2:0]  sel8;
    logic [2:0]  gp8;
    logic [7:0]  oh8;

    // 5-source instance
    logic [4:0]  req5  = '0;
    logic [14:0] prio5 = '0;
    logic        ack5  = 1'b0;
    logic        v5;
    logic [2:0]  sel5;
    logic [2:0]  gp5;
    logic [4:0]  oh5;

    prio_arbiter_rr #(.N(8), .PRIO_BITS(3)) dut8 (
        .clk_i(clk), .rst_i(rst), .req_i(req8), .prio_i(prio8), .ack_i(ack8),
        .gnt_valid_o(v8), .gnt_sel_o(sel8), .gnt_prio_o(gp8), .gnt_onehot_o(oh8)
    );

    prio_arbiter_rr #(.N(5), .PRIO_BITS(3)) dut5 (
        .clk_i(clk), .rst_i(rst), .req_i(req5), .prio_i(prio5), .ack_i(ack5),
        .gnt_valid_o(v5), .gnt_sel_o(sel5), .gnt_prio_o(gp5), .gnt_onehot_o(oh5)
    );

    // Scoreboard state
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [5:0] exp_q8[$];
    logic [5:0] exp_q5[$];
    int         last_m[2];
    logic       prev_v[2];
    logic [2:0] prev_sel[2];
    logic [2:0] prev_p[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rule: lowest priority value among requesters; among equals the
    // one closest after the last acknowledged source in circular order.
    function automatic int exp_winner(input int n, input logic [7:0] r,
                                      input logic [23:0] p, input int last);
        int best   = -1;
        int best_p = 0;
        int best_d = 0;
        for (int k = 0; k < n; k++) begin
            if (r[k]) begin
                int pk = int'(p[k*3 +: 3]);
                int dk = (k - last - 1 + n) % n;
                if (best < 0 || pk < best_p || (pk == best_p && dk < best_d)) begin
                    best = k; best_p = pk; best_d = dk;
                end
            end
        end
        return best;
    endfunction

    function automatic logic cur_valid(input int which);
        return (which == 0) ? v8 : v5;
    endfunction

    // Driver tasks
    task automatic drive(input int which, input logic [7:0] r, input logic [23:0] p, input logic a);
        if (which == 0) begin
            req8 = r; prio8 = p; ack8 = a;
        end else begin
            req5 = r[4:0]; prio5 = p[14:0]; ack5 = a;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_v8"}, {31'd0, v8}, 32'd0);
        check({tag, "_sel8"}, {29'd0, sel8}, 32'd0);
        check({tag, "_prio8"}, {29'd0, gp8}, 32'd0);
        check({tag, "_oh8"}, {24'd0, oh8}, 32'd0);
        check({tag, "_v5"}, {31'd0, v5}, 32'd0);
        check({tag, "_oh5"}, {27'd0, oh5}, 32'd0);
    endtask

    task automatic idle_cycles(input int k);
        drive(0, 8'h00, 24'h0, 1'b0);
        drive(1, 8'h00, 24'h0, 1'b0);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            check_zero("idle");
        end
    endtask

    // mode 0: ack, mode 1: request drop, mode 2: ack together with drop
    task automatic grant_txn(input int which, input logic [7:0] r_in, input logic [23:0] p,
                             input int hold, input int mode);
        int          n    = (which == 0) ? 8 : 5;
        logic [7:0]  mask = (which == 0) ? 8'hFF : 8'h1F;
        logic [7:0]  r    = r_in & mask;
        logic [7:0]  rr;
        logic [23:0] pp;
        logic        a;
        int          w;
        if (r == 8'h00) r[$urandom_range(0, n - 1)] = 1'b1;
        w = exp_winner(n, r, p, last_m[which]);
        if (which == 0) exp_q8.push_back({3'(w), p[w*3 +: 3]});
        else            exp_q5.push_back({3'(w), p[w*3 +: 3]});
        drive(which, r, p, 1'b0);
        @(posedge clk); #1;
        check("grant_latency", {31'd0, cur_valid(which)}, 32'd1);
        rr = r;
        pp = p;
        for (int h = 0; h < hold; h++) begin
            rr = (r | 8'($urandom)) & mask;
            pp = 24'($urandom);
            if (h == 0 && w != 0) begin
                rr[0]    = 1'b1;
                pp[2:0]  = 3'd0;
            end
            drive(which, rr, pp, 1'b0);
            @(posedge clk); #1;
            check("grant_held", {31'd0, cur_valid(which)}, 32'd1);
        end
        a = (mode != 1);
        if (mode >= 1) rr[w] = 1'b0;
        drive(which, rr, pp, a);
        @(posedge clk); #1;
        check("grant_released", {31'd0, cur_valid(which)}, 32'd0);
        if (a) last_m[which] = w;
        drive(which, 8'h00, pp, 1'b0);
    endtask

    function automatic logic [23:0] rand_prio();
        logic [23:0] p;
        int          top = ($urandom_range(0, 1) == 1) ? 1 : 7;
        for (int k = 0; k < 8; k++) p[k*3 +: 3] = 3'($urandom_range(0, top));
        return p;
    endfunction

    // Monitor: pops the expected grant on each rising gnt_valid_o, checks the
    // grant stays frozen while held and the one-hot/range invariants.
    task automatic mon_step(input int which, input logic v, input logic [2:0] sel,
                            input logic [2:0] gp, input logic [7:0] oh, input int n);
        logic [5:0] e;
        logic [7:0] oh_exp;
        if (v && !prev_v[which]) begin
            if ((which == 0 && exp_q8.size() == 0) || (which == 1 && exp_q5.size() == 0)) begin
                check("unexpected_grant", 32'd1, 32'd0);
            end else begin
                e = (which == 0) ? exp_q8.pop_front() : exp_q5.pop_front();
                check("grant_sel", {29'd0, sel}, {29'd0, e[5:3]});
                check("grant_prio", {29'd0, gp}, {29'd0, e[2:0]});
            end
        end else if (v && prev_v[which]) begin
            check("frozen_sel", {29'd0, sel}, {29'd0, prev_sel[which]});
            check("frozen_prio", {29'd0, gp}, {29'd0, prev_p[which]});
        end
        oh_exp = v ? (8'd1 << sel) : 8'd0;
        check("onehot", {24'd0, oh}, {24'd0, oh_exp});
        check("sel_range", {31'd0, (int'(sel) < n)}, 32'd1);
        prev_v[which]   = v;
        prev_sel[which] = sel;
        prev_p[which]   = gp;
    endtask

    always @(negedge clk) begin
        mon_step(0, v8, sel8, gp8, oh8, 8);
        mon_step(1, v5, sel5, gp5, {3'd0, oh5}, 5);
    end

    // Stimulus
    initial begin
        prev_v   = '{1'b0, 1'b0};
        prev_sel = '{3'd0, 3'd0};
        prev_p   = '{3'd0, 3'd0};
        last_m   = '{7, 4};
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("in_reset");
        rst = 1'b0;

        // Reset then idle
        idle_cycles(5);

        // Strict priority, no preemption by src0 at prio 0
        grant_txn(0, 8'b1010_0100, (24'd5 << 6) | (24'd1 << 15) | (24'd3 << 21), 3, 0);
        idle_cycles(1);

        // Round-robin among equal priorities, back to back
        for (int i = 0; i < 9; i++) grant_txn(0, 8'hFF, 24'o44444444, 0, 0);
        idle_cycles(1);

        // Non-power-of-two: src0 then src4
        grant_txn(1, 8'b1_0001, 24'o22222, 1, 0);
        grant_txn(1, 8'b1_0000, 24'o22222, 0, 0);
        idle_cycles(1);

        // Withdrawal leaves rotation alone; ack with drop advances it
        grant_txn(0, 8'h08, 24'o44444444, 1, 1);
        grant_txn(0, 8'hFF, 24'o44444444, 0, 0);
        grant_txn(0, 8'h08, 24'o44444444, 0, 2);
        grant_txn(0, 8'hFF, 24'o44444444, 0, 0);
        idle_cycles(1);

        // Async reset while a grant is held
        exp_q8.push_back({3'(exp_winner(8, 8'hFF, 24'o33333333, last_m[0])), 3'd3});
        drive(0, 8'hFF, 24'o33333333, 1'b0);
        @(posedge clk); #1;
        check("pre_reset_grant", {31'd0, v8}, 32'd1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        last_m = '{7, 4};
        grant_txn(0, 8'hFF, 24'o55555555, 0, 0);
        grant_txn(1, 8'h1F, 24'o55555, 0, 0);
        idle_cycles(1);

        // Randomized traffic on both instances
        for (int i = 0; i < 90; i++) begin
            int which = (i % 3 == 2) ? 1 : 0;
            grant_txn(which, 8'($urandom), rand_prio(), $urandom_range(0, 3), $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(2);

        check("queue8_drained", exp_q8.size(), 32'd0);
        check("queue5_drained", exp_q5.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_arbiter_rr.md
Name: prio_arbiter_rr

Overview:
- Clocked, N-source priority arbiter with a grant/acknowledge handshake and round-robin fairness among sources of equal priority.
- Successor to the combinational 2:1 tree arbiter: any N ≥ 2, not only powers of two. The grant is registered and held until it is acknowledged.
- Sits between bus masters (or interrupt sources) and a shared resource. Priority 0 is the highest.

Parameters:
- N, 8, number of sources (≥2, any value).
- PRIO_BITS, 3, width of each priority field.
- SEL_W, $clog2(N), width of the selection index (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- req_i  in  N  per-source request level.
- prio_i  in  N*PRIO_BITS  packed priorities; source k occupies bits [k*PRIO_BITS +: PRIO_BITS].
- ack_i  in  1  consumer accepts and completes the current grant.
- gnt_valid_o  out  1  a grant is held.
- gnt_sel_o  out  SEL_W  index of the granted source.
- gnt_prio_o  out  PRIO_BITS  priority captured at grant time.
- gnt_onehot_o  out  N  one-hot form of gnt_sel_o; all zero when there is no grant.

Interface decision: one clock (clk_i); reset rst_i is asynchronous and active-high.

Behaviour:
- Reset values:
  - gnt_valid_o=0, gnt_sel_o=0, gnt_prio_o=0, gnt_onehot_o=0.
  - State IDLE.
  - Internal last_q=N-1, so source 0 is first in rotation after reset.
- Pick function (combinational, evaluated in IDLE):
  - Among sources k with req_i[k]=1, the winner has the minimum prio value.
  - Ties go to the first tied source found scanning (last_q+1) mod N upward, wrapping at N.
  - Indices ≥ N do not exist; there is no phantom source.
- State IDLE:
  - If any req_i bit is set at a rising edge, then on that edge: capture the winner into gnt_sel_o, gnt_prio_o and gnt_onehot_o; set gnt_valid_o=1; go to GRANT. Latency is 1 cycle.
  - With no requests, stay in IDLE with all outputs at reset values.
  - ack_i is ignored in IDLE.
- State GRANT:
  - Outputs are frozen. prio_i changes and new higher-priority requests do not preempt.
  - ack_i=1 at an edge: last_q <= gnt_sel_o; clear all grant outputs; go to IDLE.
  - Otherwise, if req_i[gnt_sel_o] drops to 0 at an edge: withdraw the grant (outputs cleared, back to IDLE); last_q is unchanged.
  - ack_i wins over a simultaneous request drop; the rotation advances.
- Arbitration bubble:
  - One idle cycle always separates consecutive grants; gnt_valid_o is low for at least 1 cycle after ack.
  - Back-to-back throughput is one grant per 2 cycles plus the hold time.
- Rotation:
  - last_q changes only on ack.
  - last_q wrap: last_q=N-1 means the scan starts at 0.
- Reset mid-GRANT: outputs and last_q return to reset values immediately (asynchronous), with no ack semantics.
- Invariants:
  - gnt_onehot_o == (gnt_valid_o ? 1<<gnt_sel_o : 0).
  - gnt_valid_o=1 implies the granted source was requesting at capture.

Decomposition:
- Package prio_arb_pkg holds:
  - function sel_width(N) = max(1, $clog2(N)), used for SEL_W so that N=2 yields width 1;
  - state encoding constants ST_IDLE / ST_GRANT.
- One combinational sub-module, rr_prio_pick (params N, PRIO_BITS):
  - inputs req, prio, last;
  - outputs any, sel, prio_min.
  - Implement it as a rotated linear scan with a strict-less-than compare, so the first tied source in rotation order wins.
  - It must be testable standalone.
- Top level holds the FSM, last_q and the output registers.

Test Plan:
1. Reset then idle: rst_i pulse, req_i=0 for 5 cycles -> gnt_valid_o=0 and all outputs 0 throughout.
2. Strict priority, N=8: req_i=8'b1010_0100, prios src2=5, src5=1, src7=3 -> one edge later gnt_sel_o=5, gnt_prio_o=1, gnt_onehot_o=8'h20; the grant holds while src0 is raised with prio 0 (no preemption).
3. Round-robin tie: all 8 requesting at prio 4, ack_i pulsed each time valid is seen -> grant order 0,1,2,…,7,0, with a 1-cycle gap of gnt_valid_o=0 between grants.
4. Non-power-of-two N=5: src4 and src0 at equal prio, last_q=4 -> src0 granted; after ack, src4 still requesting alone -> src4 granted; sel never exceeds 4.
5. Withdrawal: src3 granted, req_i[3] drops without ack -> grant cleared next edge and last_q unchanged; if ack_i arrives in the same cycle as the drop -> last_q=3.
6. Async reset mid-grant: assert rst_i between clock edges while gnt_valid_o=1 -> outputs go to 0 before the next edge; after release with equal-prio requests, source 0 is granted first.
